// File: rtl/cond_issue_ctrl_if.sv
// cond_issue_ctrl_if
//   Bundles the decode offer, flag writeback, flush and issue outputs of the
//   conditional issue controller.
//   slave  : the controller (takes id_*/wb_*/flush, drives id_ready/ex_*/status/err)
//   master : the surrounding pipeline (opposite directions)
interface cond_issue_ctrl_if;
    logic       id_valid;
    logic [3:0] id_cond;
    logic       id_set_flags;
    logic       id_ready;
    logic       wb_flag_we;
    logic [3:0] wb_flags;      // [3]=N [2]=Z [1]=C [0]=V
    logic       flush;
    logic       ex_valid;
    logic       ex_execute;
    logic       ex_set_flags;
    logic [3:0] status;
    logic       err_underflow;

    modport slave (
        input  id_valid, id_cond, id_set_flags, wb_flag_we, wb_flags, flush,
        output id_ready, ex_valid, ex_execute, ex_set_flags, status, err_underflow
    );

    modport master (
        output id_valid, id_cond, id_set_flags, wb_flag_we, wb_flags, flush,
        input  id_ready, ex_valid, ex_execute, ex_set_flags, status, err_underflow
    );
endinterface

// File: rtl/cond_issue_ctrl.sv
// cond_issue_ctrl
//   Issue gate for ARM-style conditional instructions. Tracks how many
//   flag-writing instructions are still in flight (pend) and holds back any
//   conditional instruction until the NZCV it depends on is architectural.
//   Always (1110) and never (1111) instructions do not depend on flags and may
//   issue while writers are pending.
// Ports
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : cond_issue_ctrl_if.slave (decode offer/ready, flag writeback,
//                flush, registered ex_* issue outputs, status, err_underflow)
// Parameters
//   PEND_W     : width of the pending-writer counter, MAX_PEND = 2^PEND_W-1
// Build option
//   COND_FLAG_FORWARD_EN : when defined, a conditional instruction waiting on
//   the last pending writer issues in the writeback cycle, evaluated against
//   wb_flags. Undefined: it issues the cycle after status is updated.
module cond_issue_ctrl #(
    parameter int PEND_W = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    cond_issue_ctrl_if.slave bus
);

    typedef enum logic {ST_RUN, ST_WAIT} state_t;

    localparam logic [PEND_W-1:0] MAX_PEND = '1;
    localparam logic [PEND_W-1:0] ONE      = PEND_W'(1);

    state_t            state, state_next;
    logic [PEND_W-1:0] pend, pend_next;
    logic              fwd_ok;
    logic [3:0]        flag_src;
    logic              uncond;
    logic              pass;
    logic              accept;
    logic              inc, dec;

    // NZCV condition check, standard ARM encoding. Odd codes invert the even
    // code below them, except 1111 which never passes.
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        n  = f[3];
        z  = f[2];
        cf = f[1];
        v  = f[0];
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cf;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cf & ~z;
            3'd5:    base = (n == v);
            3'd6:    base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return (c == 4'hF) ? 1'b0 : (base ^ c[0]);
    endfunction

`ifdef COND_FLAG_FORWARD_EN
    // Last pending writer is retiring this cycle: its flags are exact.
    assign fwd_ok = (state == ST_WAIT) && (pend == ONE) && bus.wb_flag_we;
`else
    assign fwd_ok = 1'b0;
`endif

    assign flag_src = fwd_ok ? bus.wb_flags : bus.status;
    assign uncond   = (bus.id_cond == 4'hE) || (bus.id_cond == 4'hF);
    assign pass     = cond_pass(bus.id_cond, flag_src);

    // Ready is purely combinational; a simultaneous writeback frees a slot so
    // a flag setter can issue even with the counter full.
    always_comb begin
        bus.id_ready = 1'b1;
        if (bus.id_set_flags && (pend == MAX_PEND) && !bus.wb_flag_we)
            bus.id_ready = 1'b0;
        if ((state == ST_WAIT) && !uncond && !fwd_ok)
            bus.id_ready = 1'b0;
        if (bus.flush)
            bus.id_ready = 1'b0;
    end

    assign accept = bus.id_valid && bus.id_ready;
    assign inc    = accept && bus.id_set_flags && pass;
    // A writeback with nothing pending is an error, never a wrap.
    assign dec    = bus.wb_flag_we && (pend != '0);

    always_comb begin
        pend_next  = pend;
        state_next = state;
        if (bus.flush) begin
            pend_next  = '0;
            state_next = ST_RUN;
        end else begin
            if (inc && !dec)
                pend_next = pend + ONE;
            else if (dec && !inc)
                pend_next = pend - ONE;
            case (state)
                ST_RUN:  if (inc)               state_next = ST_WAIT;
                ST_WAIT: if (pend_next == '0)   state_next = ST_RUN;
                default:                        state_next = ST_RUN;
            endcase
            // A writeback racing the first setter can leave pend nonzero
            // without passing through the RUN->WAIT transition above.
            if (pend_next != '0)
                state_next = ST_WAIT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
            pend  <= '0;
        end else begin
            state <= state_next;
            pend  <= pend_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ex_valid      <= 1'b0;
            bus.ex_execute    <= 1'b0;
            bus.ex_set_flags  <= 1'b0;
            bus.status        <= 4'h0;
            bus.err_underflow <= 1'b0;
        end else begin
            if (bus.flush) begin
                bus.ex_valid     <= 1'b0;
                bus.ex_execute   <= 1'b0;
                bus.ex_set_flags <= 1'b0;
            end else begin
                bus.ex_valid     <= accept;
                bus.ex_execute   <= accept && pass;
                bus.ex_set_flags <= inc;
            end
            // Flags from an already-executed writer land even across a flush.
            if (bus.wb_flag_we)
                bus.status <= bus.wb_flags;
            if (bus.wb_flag_we && (pend == '0))
                bus.err_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cond_issue_ctrl.sv
module tb_cond_issue_ctrl;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    cond_issue_ctrl_if bus();

    cond_issue_ctrl #(.PEND_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] st;
        logic [3:0] cond;
        logic       sf;
        logic       exe;
        logic       esf;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.id_valid     = 1'b0;
        bus.id_cond      = 4'h0;
        bus.id_set_flags = 1'b0;
        bus.wb_flag_we   = 1'b0;
        bus.wb_flags     = 4'h0;
        bus.flush        = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic offer(input logic [3:0] c, input logic sf);
        bus.id_valid     = 1'b1;
        bus.id_cond      = c;
        bus.id_set_flags = sf;
    endtask

    // Reference condition check written out per code.
    function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cf && !z;
            4'h9: return !cf || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        n_tests = 0;
        n_fail  = 0;

        vecs[0]  = '{4'b0000, 4'b0001, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{4'b0100, 4'b0000, 1'b1, 1'b1, 1'b1};
        vecs[4]  = '{4'b1001, 4'b1010, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{4'b1000, 4'b1010, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{4'b1000, 4'b1011, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{4'b0010, 4'b1000, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{4'b0110, 4'b1000, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{4'b0110, 4'b1001, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{4'b0000, 4'b1100, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{4'b1000, 4'b1101, 1'b1, 1'b1, 1'b1};
        vecs[12] = '{4'b1111, 4'b1110, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0};

        // Reset state
        idle();
        rst_n = 1'b0;
        #2;
        chk("rst_status", int'(bus.status), 0);
        chk("rst_ex_valid", int'(bus.ex_valid), 0);
        chk("rst_err", int'(bus.err_underflow), 0);
        chk("rst_ready", int'(bus.id_ready), 1);
        tick();
        rst_n = 1'b1;
        tick();

        // Directed vectors: load status by writeback (which also retires any
        // writer left by the previous vector), then offer one instruction.
        for (int i = 0; i < 14; i++) begin
            idle();
            bus.wb_flag_we = 1'b1;
            bus.wb_flags   = vecs[i].st;
            tick();
            idle();
            offer(vecs[i].cond, vecs[i].sf);
            #1;
            chk($sformatf("vec%0d_ready", i), int'(bus.id_ready), 1);
            tick();
            chk($sformatf("vec%0d_valid", i), int'(bus.ex_valid), 1);
            chk($sformatf("vec%0d_exec", i), int'(bus.ex_execute), int'(vecs[i].exe));
            chk($sformatf("vec%0d_setf", i), int'(bus.ex_set_flags), int'(vecs[i].esf));
            chk($sformatf("vec%0d_pend", i), int'(dut.pend), int'(vecs[i].esf));
        end
        idle();
        tick();

        // Full condition sweep in RUN
        do_reset();
        for (int s = 0; s < 16; s++) begin
            idle();
            bus.wb_flag_we = 1'b1;
            bus.wb_flags   = 4'(s);
            tick();
            for (int c = 0; c < 16; c++) begin
                idle();
                offer(4'(c), 1'b0);
                tick();
                chk($sformatf("sweep_s%0d_c%0d", s, c), int'(bus.ex_execute), int'(ref_pass(4'(c), 4'(s))));
            end
        end
        idle();
        tick();

        // Compare-branch hazard
        do_reset();
        offer(4'hE, 1'b1);
        #1 chk("haz_setter_ready", int'(bus.id_ready), 1);
        tick();
        chk("haz_setter_setf", int'(bus.ex_set_flags), 1);
        offer(4'h0, 1'b0);
        #1 chk("haz_wait_ready", int'(bus.id_ready), 0);
        tick();
        chk("haz_wait_valid", int'(bus.ex_valid), 0);
        bus.wb_flag_we = 1'b1;
        bus.wb_flags   = 4'b0100;
        #1;
`ifdef COND_FLAG_FORWARD_EN
        chk("haz_wb_ready", int'(bus.id_ready), 1);
        tick();
        chk("haz_fwd_valid", int'(bus.ex_valid), 1);
        chk("haz_fwd_exec", int'(bus.ex_execute), 1);
        idle();
        tick();
`else
        chk("haz_wb_ready", int'(bus.id_ready), 0);
        tick();
        chk("haz_wb_valid", int'(bus.ex_valid), 0);
        chk("haz_status", int'(bus.status), 4);
        bus.wb_flag_we = 1'b0;
        #1 chk("haz_after_ready", int'(bus.id_ready), 1);
        tick();
        chk("haz_after_valid", int'(bus.ex_valid), 1);
        chk("haz_after_exec", int'(bus.ex_execute), 1);
        idle();
        tick();
`endif
        chk("haz_err", int'(bus.err_underflow), 0);

        // Full stall with three writers pending
        do_reset();
        for (int k = 0; k < 3; k++) begin
            offer(4'hE, 1'b1);
            #1 chk($sformatf("stall_fill%0d_ready", k), int'(bus.id_ready), 1);
            tick();
        end
        chk("stall_pend3", int'(dut.pend), 3);
        offer(4'hE, 1'b1);
        #1 chk("stall_ready", int'(bus.id_ready), 0);
        tick();
        chk("stall_valid", int'(bus.ex_valid), 0);
        bus.wb_flag_we = 1'b1;
        bus.wb_flags   = 4'b0000;
        #1 chk("stall_wb_ready", int'(bus.id_ready), 1);
        tick();
        chk("stall_wb_valid", int'(bus.ex_valid), 1);
        chk("stall_wb_pend", int'(dut.pend), 3);
        idle();
        tick();

        // Flush with two writers pending
        do_reset();
        offer(4'hE, 1'b1);
        tick();
        tick();
        chk("flush_pend2", int'(dut.pend), 2);
        bus.flush = 1'b1;
        tick();
        chk("flush_valid", int'(bus.ex_valid), 0);
        chk("flush_setf", int'(bus.ex_set_flags), 0);
        chk("flush_pend0", int'(dut.pend), 0);
        idle();
        offer(4'h0, 1'b0);
        #1 chk("flush_run_ready", int'(bus.id_ready), 1);
        idle();
        bus.wb_flag_we = 1'b1;
        bus.wb_flags   = 4'b1010;
        tick();
        chk("flush_err", int'(bus.err_underflow), 1);
        chk("flush_status", int'(bus.status), 10);
        chk("flush_pend_hold", int'(dut.pend), 0);
        idle();
        tick();

        // Asynchronous reset in the middle of WAIT with pend=2
        do_reset();
        bus.wb_flag_we = 1'b1;
        bus.wb_flags   = 4'b1111;
        tick();
        idle();
        offer(4'hE, 1'b1);
        tick();
        tick();
        offer(4'h0, 1'b0);
        #1 chk("rst_wait_ready", int'(bus.id_ready), 0);
        chk("rst_wait_pend", int'(dut.pend), 2);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_status", int'(bus.status), 0);
        chk("rst_mid_valid", int'(bus.ex_valid), 0);
        chk("rst_mid_err", int'(bus.err_underflow), 0);
        chk("rst_mid_ready", int'(bus.id_ready), 1);
        tick();
        rst_n = 1'b1;
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
